// File: rtl/pc_unit.sv
// Program-counter stage of the single-cycle RV32 core.
// Holds the current PC, selects the next PC, raises one-cycle traps on
// misaligned redirects or a reserved pc_src encoding, parks in HALT on
// ECALL/EBREAK, and counts retired instructions.
//
// Flow control: en is the only advance qualifier. When en=1 in RUN the
// instruction at pc completes this cycle; when en=0 every register holds.
// BOOT and TRAP advance regardless of en; HALT never advances.
//
// FSM state is fully visible on the outputs: running=RUN, trap=TRAP,
// halted=HALT, and all three low means BOOT.
module pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    input  logic [1:0]  pc_src,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic        running,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] epc,
    output logic [31:0] bad_addr,
    output logic        halted,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [1:0] SRC_SEQ  = 2'b00;
    localparam logic [1:0] SRC_BR   = 2'b01;
    localparam logic [1:0] SRC_JALR = 2'b10;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic [1:0]  trap_cause_q, trap_cause_d;
    logic [31:0] target;

    // Candidate next PC; JALR clears bit 0 before the alignment check.
    always_comb begin
        target = pc_plus4;
        case (pc_src)
            SRC_SEQ:  target = pc_plus4;
            SRC_BR:   target = br_target;
            SRC_JALR: target = jalr_target & 32'hFFFF_FFFE;
            default:  target = pc_plus4;
        endcase
    end

    // Next-state and next-register logic; everything holds unless a case below says otherwise.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instret_d    = instret_q;
        epc_d        = epc_q;
        bad_addr_d   = bad_addr_q;
        trap_cause_d = trap_cause_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (en) begin
                    if (halt_req) begin
                        instret_d = instret_q + 32'd1;
                        state_d   = ST_HALT;
                    end else if (pc_src == 2'b11) begin
                        epc_d        = pc_q;
                        bad_addr_d   = 32'h0000_0000;
                        trap_cause_d = CAUSE_ILLEGAL;
                        state_d      = ST_TRAP;
                    end else if (target[1:0] != 2'b00) begin
                        epc_d        = pc_q;
                        bad_addr_d   = target;
                        trap_cause_d = CAUSE_MISALIGNED;
                        state_d      = ST_TRAP;
                    end else begin
                        pc_d      = target;
                        instret_d = instret_q + 32'd1;
                    end
                end
            end
            ST_TRAP: begin
                pc_d    = TRAP_VECTOR;
                state_d = ST_RUN;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and datapath registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            instret_q    <= 32'h0000_0000;
            epc_q        <= 32'h0000_0000;
            bad_addr_q   <= 32'h0000_0000;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instret_q    <= instret_d;
            epc_q        <= epc_d;
            bad_addr_q   <= bad_addr_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign pc         = pc_q;
    assign instret    = instret_q;
    assign epc        = epc_q;
    assign bad_addr   = bad_addr_q;
    assign trap_cause = trap_cause_q;
    assign running    = (state_q == ST_RUN);
    assign trap       = (state_q == ST_TRAP);
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: each scenario task drives one cycle at a time, pushes
// the expected post-edge observation into exp_q, captures the DUT outputs
// into got_q, and compares the two queues at the end of the scenario.
module tb_pc_unit;

    localparam int OW = 133;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_TRAP = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jalr_target;
    logic [1:0]  pc_src;
    logic        halt_req;
    logic [31:0] pc;
    logic        running;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] epc;
    logic [31:0] bad_addr;
    logic        halted;
    logic [31:0] instret;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got_q[$];
    int n_vec;
    int n_err;

    pc_unit #(
        .RESET_PC   (32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pc_plus4   (pc_plus4),
        .br_target  (br_target),
        .jalr_target(jalr_target),
        .pc_src     (pc_src),
        .halt_req   (halt_req),
        .pc         (pc),
        .running    (running),
        .trap       (trap),
        .trap_cause (trap_cause),
        .epc        (epc),
        .bad_addr   (bad_addr),
        .halted     (halted),
        .instret    (instret)
    );

    // The PC+4 adder sitting downstream of the PC register.
    assign pc_plus4 = pc + 32'd4;

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build an expected observation: {pc, instret, epc, bad_addr, cause, running, trap, halted}.
    function automatic logic [OW-1:0] ev(input logic [31:0] e_pc, input logic [31:0] e_ir,
                                         input logic [31:0] e_epc, input logic [31:0] e_bad,
                                         input logic [1:0] e_tc, input logic [1:0] e_st);
        logic [2:0] fl;
        fl = 3'b000;
        if (e_st == S_RUN)  fl = 3'b100;
        if (e_st == S_TRAP) fl = 3'b010;
        if (e_st == S_HALT) fl = 3'b001;
        return {e_pc, e_ir, e_epc, e_bad, e_tc, fl};
    endfunction

    // Driver: apply one cycle of stimulus, record expectation, capture outputs after the edge.
    task automatic drive(input logic d_rst, input logic d_en, input logic [1:0] d_src,
                         input logic d_halt, input logic [31:0] d_br, input logic [31:0] d_jr,
                         input logic [OW-1:0] e);
        rst         = d_rst;
        en          = d_en;
        pc_src      = d_src;
        halt_req    = d_halt;
        br_target   = d_br;
        jalr_target = d_jr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got_q.push_back({pc, instret, epc, bad_addr, trap_cause, running, trap, halted});
    endtask

    task automatic test_reset();
        logic [OW-1:0] g, e;
        int k;
        drive(1, 1, 2'b11, 1, $urandom, $urandom, ev(32'h0, 0, 0, 0, 2'b00, S_BOOT));
        drive(1, 1, 2'b01, 0, $urandom, $urandom, ev(32'h0, 0, 0, 0, 2'b00, S_BOOT));
        drive(0, 1, 2'b11, 1, $urandom, $urandom, ev(32'h0, 0, 0, 0, 2'b00, S_RUN));
        drive(0, 1, 2'b00, 0, $urandom, $urandom, ev(32'h4, 1, 0, 0, 2'b00, S_RUN));
        drive(0, 1, 2'b00, 0, $urandom, $urandom, ev(32'h8, 2, 0, 0, 2'b00, S_RUN));
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL reset step %0d: got %h required %h", k, g, e);
            end
            k++;
        end
    endtask

    task automatic test_stall_branch();
        logic [OW-1:0] g, e;
        int k;
        for (int i = 0; i < 3; i++)
            drive(0, 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  ev(32'h8, 2, 0, 0, 2'b00, S_RUN));
        drive(0, 1, 2'b01, 0, 32'h40, $urandom, ev(32'h40, 3, 0, 0, 2'b00, S_RUN));
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL stall_branch step %0d: got %h required %h", k, g, e);
            end
            k++;
        end
    endtask

    task automatic test_jalr_misalign();
        logic [OW-1:0] g, e;
        int k;
        drive(0, 1, 2'b10, 0, $urandom, 32'h81, ev(32'h80, 4, 0, 0, 2'b00, S_RUN));
        drive(0, 1, 2'b10, 0, $urandom, 32'h82, ev(32'h80, 4, 32'h80, 32'h82, 2'b01, S_TRAP));
        drive(0, 0, 2'b11, 1, $urandom, $urandom, ev(32'h100, 4, 32'h80, 32'h82, 2'b01, S_RUN));
        drive(0, 1, 2'b01, 0, 32'h106, $urandom, ev(32'h100, 4, 32'h100, 32'h106, 2'b01, S_TRAP));
        drive(0, 1, 2'b00, 0, $urandom, $urandom, ev(32'h100, 4, 32'h100, 32'h106, 2'b01, S_RUN));
        drive(0, 1, 2'b00, 0, $urandom, $urandom, ev(32'h104, 5, 32'h100, 32'h106, 2'b01, S_RUN));
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL jalr_misalign step %0d: got %h required %h", k, g, e);
            end
            k++;
        end
    endtask

    task automatic test_illegal_src();
        logic [OW-1:0] g, e;
        int k;
        drive(0, 1, 2'b01, 0, 32'h10, $urandom, ev(32'h10, 6, 32'h100, 32'h106, 2'b01, S_RUN));
        drive(0, 1, 2'b11, 0, 32'h3, 32'h7, ev(32'h10, 6, 32'h10, 32'h0, 2'b10, S_TRAP));
        drive(0, 1, 2'b01, 0, 32'h44, $urandom, ev(32'h100, 6, 32'h10, 32'h0, 2'b10, S_RUN));
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL illegal_src step %0d: got %h required %h", k, g, e);
            end
            k++;
        end
    endtask

    task automatic test_wrap();
        logic [OW-1:0] g, e;
        int k;
        drive(0, 1, 2'b01, 0, 32'hFFFF_FFFC, $urandom, ev(32'hFFFF_FFFC, 7, 32'h10, 0, 2'b10, S_RUN));
        drive(0, 1, 2'b00, 0, $urandom, $urandom, ev(32'h0, 8, 32'h10, 0, 2'b10, S_RUN));
        force dut.instret_q = 32'hFFFF_FFFF;
        drive(0, 0, 2'b00, 0, $urandom, $urandom, ev(32'h0, 32'hFFFF_FFFF, 32'h10, 0, 2'b10, S_RUN));
        release dut.instret_q;
        drive(0, 1, 2'b00, 0, $urandom, $urandom, ev(32'h4, 32'h0, 32'h10, 0, 2'b10, S_RUN));
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL wrap step %0d: got %h required %h", k, g, e);
            end
            k++;
        end
    endtask

    task automatic test_halt();
        logic [OW-1:0] g, e;
        int k;
        drive(0, 1, 2'b01, 1, 32'h40, $urandom, ev(32'h4, 1, 32'h10, 0, 2'b10, S_HALT));
        for (int i = 0; i < 5; i++)
            drive(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, ev(32'h4, 1, 32'h10, 0, 2'b10, S_HALT));
        drive(1, 1, 2'b00, 0, $urandom, $urandom, ev(32'h0, 0, 0, 0, 2'b00, S_BOOT));
        drive(0, 1, 2'b00, 0, $urandom, $urandom, ev(32'h0, 0, 0, 0, 2'b00, S_RUN));
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL halt step %0d: got %h required %h", k, g, e);
            end
            k++;
        end
    endtask

    task automatic test_midtrap_reset();
        logic [OW-1:0] g, e;
        int k;
        drive(0, 1, 2'b00, 0, $urandom, $urandom, ev(32'h4, 1, 0, 0, 2'b00, S_RUN));
        drive(0, 1, 2'b11, 0, $urandom, $urandom, ev(32'h4, 1, 32'h4, 0, 2'b10, S_TRAP));
        drive(1, 1, 2'b00, 0, $urandom, $urandom, ev(32'h0, 0, 0, 0, 2'b00, S_BOOT));
        drive(0, 1, 2'b00, 0, $urandom, $urandom, ev(32'h0, 0, 0, 0, 2'b00, S_RUN));
        // halt_req outranks a reserved pc_src
        drive(0, 1, 2'b11, 1, $urandom, $urandom, ev(32'h0, 1, 0, 0, 2'b00, S_HALT));
        drive(1, 0, 2'b00, 0, $urandom, $urandom, ev(32'h0, 0, 0, 0, 2'b00, S_BOOT));
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL midtrap_reset step %0d: got %h required %h", k, g, e);
            end
            k++;
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        en          = 1'b0;
        pc_src      = 2'b00;
        halt_req    = 1'b0;
        br_target   = 32'h0;
        jalr_target = 32'h0;
        @(negedge clk);
        test_reset();
        test_stall_branch();
        test_jalr_misalign();
        test_illegal_src();
        test_wrap();
        test_halt();
        test_midtrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage of the single-cycle RV32 core; directly upstream of the PC+4 Adder.
- Drives `pc` into instruction memory and into the Adder's `op1`, with `op2` tied to 4.
- Takes the Adder's `res` back as `pc_plus4` and selects the next PC from sequential, PC-relative (branch/JAL) and JALR targets.
- Adds stall, halt, misaligned/illegal-redirect trap handling and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded by reset.
- TRAP_VECTOR, 32'h00000100, PC loaded on any trap.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = stall (everything held).
- pc_plus4  in  32  sequential next PC (Adder `res`).
- br_target  in  32  PC-relative target (branch taken / JAL).
- jalr_target  in  32  rs1+imm from the ALU.
- pc_src  in  2  next-PC select: 00 seq, 01 br_target, 10 jalr_target, 11 reserved.
- halt_req  in  1  ECALL/EBREAK decoded for the current instruction.
- pc  out  32  current PC.
- running  out  1  1 when in RUN (instruction at `pc` is executing).
- trap  out  1  1 during the TRAP cycle.
- trap_cause  out  2  00 none, 01 misaligned target, 10 illegal pc_src.
- epc  out  32  PC of the faulting instruction.
- bad_addr  out  32  offending target (0 for an illegal pc_src).
- halted  out  1  1 in HALT.
- instret  out  32  retired-instruction count.

Behaviour:
- Reset: the clock edge with rst=1 forces state=BOOT and pc=RESET_PC. It clears instret, epc, bad_addr and trap_cause. Outputs running=0, trap=0, halted=0.
  - Reset overrides every state and every input, including mid-trap and HALT.
- States: BOOT, RUN, TRAP, HALT. All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- BOOT: one cycle with pc held (instruction ROM first-read settle). Unconditional transition to RUN; all inputs ignored.
- RUN, en=0: all registers hold, stay in RUN.
- RUN, en=1, evaluated in priority order:
  1. halt_req=1: the instruction retires (instret+1), pc holds, go to HALT. pc_src is ignored.
  2. pc_src=11: go to TRAP with epc=pc, bad_addr=0, trap_cause=10. pc holds, no retire.
  3. Otherwise compute the target:
     - seq → pc_plus4.
     - 01 → br_target.
     - 10 → {jalr_target[31:1],1'b0}; bit 0 is cleared before the check.
  4. If target[1:0]≠00: go to TRAP with epc=pc, bad_addr=target, trap_cause=01. pc holds, no retire.
  5. Else pc<=target, instret+1, stay in RUN.
- TRAP: trap=1 for exactly one cycle.
  - pc<=TRAP_VECTOR at the end of the cycle; next state RUN.
  - en, halt_req and pc_src are ignored.
  - epc, bad_addr and trap_cause hold until the next trap or reset; they are not cleared on return to RUN.
- HALT: pc, instret and epc frozen; halted=1. Exit only via rst.
- instret: 32-bit unsigned, wraps 32'hFFFFFFFF→0. Counts only the retire cases above.
- No alignment check on pc_plus4 beyond the common path: a wrap of pc_plus4 to 0 is legal and taken.

Test Plan:
- Reset/boot: rst=1 for 2 cycles, then 0 → pc=0, running=0 for 1 cycle, then running=1. Sequential pc_plus4 gives pc 0→4→8, instret=2 after two RUN cycles.
- Stall and branch:
  - en=0 for 3 cycles at pc=8 → pc, instret unchanged.
  - en=1, pc_src=01, br_target=32'h40 → pc=32'h40, instret+1.
- JALR and misalignment:
  - pc_src=10, jalr_target=32'h81 → pc=32'h80, since bit 0 is cleared.
  - jalr_target=32'h82 → trap=1 one cycle, trap_cause=01, bad_addr=32'h82, epc=32'h80, then pc=32'h100. instret unchanged across the trap.
- Illegal pc_src: pc_src=11 at pc=32'h10 → trap_cause=10, bad_addr=0, epc=32'h10, next pc=32'h100.
- Halt and reset exit:
  - halt_req=1 with pc_src=01 → halted=1, pc unchanged, instret+1.
  - Further inputs for 5 cycles have no effect.
  - rst=1 → pc=0, halted=0, instret=0.
- Counter wrap and mid-trap reset:
  - Force instret to 32'hFFFFFFFF via 2^32−1 retires, or a bench-forced preload → the next retire gives 0.
  - Assert rst during the TRAP cycle → next state BOOT, pc=0, trap=0.
